fifo_rd_stream: RTL

Downstream read-side adapter for the team's synchronous FIFO. It drives the FIFO read interface: r_en in, registered data_out one cycle later, with empty as status. It presents that data as a standard valid/ready stream to the next stage. A 2-entry output buffer sustains one word per cycle under no backpressure and loses or duplicates no word under backpressure. It also keeps a saturating count of delivered words.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/stream_buf2.sv | 66 ++++++
 rtl/fifo_rd_stream.sv | 66 ++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO read-side stream adapter.
package fifo_pkg;

    // Depth of the skid buffer between the FIFO read port and the stream output.
    localparam int unsigned RD_BUF_DEPTH = 2;

    // Occupancy must represent 0..RD_BUF_DEPTH inclusive.
    localparam int unsigned OCC_WIDTH = $clog2(RD_BUF_DEPTH + 1);

    typedef logic [OCC_WIDTH-1:0] occ_t;

    // Projected occupancy carries one extra bit so the sum can never wrap.
    typedef logic [OCC_WIDTH:0] occ_proj_t;

    localparam occ_proj_t OCC_LIMIT = occ_proj_t'(RD_BUF_DEPTH);

    // Occupancy the buffer will have once a read issued last cycle lands and
    // the current pop (if any) retires.
    function automatic occ_proj_t occ_next(input occ_t occ, input logic rd_pend,
                                           input logic pop);
        return {1'b0, occ} + {{OCC_WIDTH{1'b0}}, rd_pend} - {{OCC_WIDTH{1'b0}}, pop};
    endfunction

endpackage

// File: rtl/stream_buf2.sv
// Two-entry register buffer with push/pop and occupancy. Output data is read
// straight from the storage registers, so it is stable while not popped.
module stream_buf2
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output occ_t                  occ,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data
);

    logic [DATA_WIDTH-1:0] buf_q [RD_BUF_DEPTH];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    occ_t                  occ_q;
    occ_t                  occ_d;
    logic                  pop_ok;

    // Pop is only meaningful when a word is held.
    assign pop_ok = pop && (occ_q != '0);

    // Next occupancy: a simultaneous push and pop leaves it unchanged.
    always_comb begin
        occ_d = occ_q;
        unique case ({push, pop_ok})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    // Storage, pointers and occupancy; all cleared on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < RD_BUF_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= '0;
        end else begin
            if (push) begin
                buf_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_d;
        end
    end

    // Head-of-buffer view.
    always_comb begin
        occ   = occ_q;
        valid = (occ_q != '0);
        data  = buf_q[rd_ptr_q];
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side adapter: turns the FIFO's r_en / registered data_out interface
// into a valid/ready stream, with a saturating delivered-word counter.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_r_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  word_count
);

    logic                 rd_pend_q;
    logic                 pop;
    occ_t                 occ;
    logic [CNT_WIDTH-1:0] word_count_q;

    assign pop = m_valid && m_ready;

    // Issue a read only if the word is guaranteed a slot when it lands; the
    // m_ready term lets a read overlap a pop for full throughput.
    always_comb begin
        fifo_r_en = rst_n && !fifo_empty && (occ_next(occ, rd_pend_q, pop) < OCC_LIMIT);
    end

    // The FIFO presents data one cycle after r_en; remember a read is in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_pend_q <= 1'b0;
        end else begin
            rd_pend_q <= fifo_r_en;
        end
    end

    // Delivered-word counter, holds at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_count_q <= '0;
        end else if (pop && (word_count_q != '1)) begin
            word_count_q <= word_count_q + 1'b1;
        end
    end

    assign word_count = word_count_q;

    stream_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_pend_q),
        .push_data (fifo_data),
        .pop       (pop),
        .occ       (occ),
        .valid     (m_valid),
        .data      (m_data)
    );

endmodule
